// File: rtl/regfile_arb_pkg.sv
// Shared types and widths for the register-file arbiter.
// Contents:
//   XLEN, REG_ADDR_W - data and register-address widths
//   rf_tag_t         - owner of a transaction in flight to the register file
//   rf_slot_tags_t   - one tag for the read slot and one for the write slot
package regfile_arb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_CORE   = 2'd1,
        TAG_DBG_RD = 2'd2,
        TAG_DBG_WR = 2'd3
    } rf_tag_t;

    // A core read and a debug write can be accepted in the same cycle, so
    // each pipeline stage carries both slots. The read slot only ever holds
    // NONE/CORE/DBG_RD and the write slot only NONE/DBG_WR.
    typedef struct packed {
        rf_tag_t rd;
        rf_tag_t wr;
    } rf_slot_tags_t;

endpackage

// File: rtl/regfile_tag_pipe.sv
// Two-stage tag shift register that tracks transactions in flight to the
// register file, matching its 2-cycle read latency.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset, clears both stages to NONE
//   tags_i - tags of the transactions accepted this cycle
//   tags_o - stage-1 tags, aligned with the register file read data
module regfile_tag_pipe
    import regfile_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  rf_slot_tags_t tags_i,
    output rf_slot_tags_t tags_o
);

    rf_slot_tags_t s0_q;
    rf_slot_tags_t s1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= '{rd: TAG_NONE, wr: TAG_NONE};
            s1_q <= '{rd: TAG_NONE, wr: TAG_NONE};
        end else begin
            s0_q <= tags_i;
            s1_q <= s0_q;
        end
    end

    assign tags_o = s1_q;

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register file between the core pipeline and the debug module:
// one read slot and one write slot per cycle. The core has priority on
// both; a pending debug read that has been denied STARVE_LIMIT consecutive
// cycles takes the read slot. Returning read data is routed to its owner
// using a 2-stage tag pipeline.
// Ports:
//   core_rd_valid/core_rs1/core_rs2/core_rd_ready      - core read request
//   core_rdata_valid/core_rs1v/core_rs2v               - core read result
//   core_wr_valid/core_wd_reg/core_wdv                 - core write (always taken)
//   dbg_req_valid/dbg_req_write/dbg_addr/dbg_wdata/dbg_req_ready - debug request
//   dbg_rsp_valid/dbg_rsp_data                         - debug response
//   rf_rs1/rf_rs2/rf_wd_reg/rf_wdv/rf_wren/rf_rs1v/rf_rs2v - register file side
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_rd_valid,
    input  logic [REG_ADDR_W-1:0] core_rs1,
    input  logic [REG_ADDR_W-1:0] core_rs2,
    output logic                  core_rd_ready,
    output logic                  core_rdata_valid,
    output logic [XLEN-1:0]       core_rs1v,
    output logic [XLEN-1:0]       core_rs2v,
    input  logic                  core_wr_valid,
    input  logic [REG_ADDR_W-1:0] core_wd_reg,
    input  logic [XLEN-1:0]       core_wdv,
    input  logic                  dbg_req_valid,
    input  logic                  dbg_req_write,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]       dbg_wdata,
    output logic                  dbg_req_ready,
    output logic                  dbg_rsp_valid,
    output logic [XLEN-1:0]       dbg_rsp_data,
    output logic [REG_ADDR_W-1:0] rf_rs1,
    output logic [REG_ADDR_W-1:0] rf_rs2,
    output logic [REG_ADDR_W-1:0] rf_wd_reg,
    output logic [XLEN-1:0]       rf_wdv,
    output logic                  rf_wren,
    input  logic [XLEN-1:0]       rf_rs1v,
    input  logic [XLEN-1:0]       rf_rs2v
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]    starve_q;
    logic [3:0]    starve_d;
    logic          dbg_rd_pend;
    logic          dbg_wr_pend;
    logic          starve_hit;
    logic          dbg_rd_gnt;
    logic          core_rd_acc;
    logic          dbg_wr_acc;
    rf_slot_tags_t tags_in;
    rf_slot_tags_t tags_out;

    // Grant decisions
    always_comb begin
        dbg_rd_pend   = dbg_req_valid & ~dbg_req_write;
        dbg_wr_pend   = dbg_req_valid &  dbg_req_write;
        starve_hit    = (starve_q == LIMIT);
        dbg_rd_gnt    = dbg_rd_pend & (~core_rd_valid | starve_hit);
        core_rd_ready = ~(starve_hit & dbg_rd_pend);
        core_rd_acc   = core_rd_valid & core_rd_ready;
        dbg_wr_acc    = dbg_wr_pend & ~core_wr_valid;
        dbg_req_ready = dbg_req_write ? ~core_wr_valid
                                      : (~core_rd_valid | starve_hit);
    end

    // Read address mux; core addresses pass through even without a request
    always_comb begin
        rf_rs1 = core_rs1;
        rf_rs2 = core_rs2;
        if (dbg_rd_gnt) begin
            rf_rs1 = dbg_addr;
            rf_rs2 = '0;
        end
    end

    // Write slot; x0 writes are forwarded, the register file drops them
    always_comb begin
        rf_wren   = core_wr_valid | dbg_wr_acc;
        rf_wd_reg = core_wr_valid ? core_wd_reg : dbg_addr;
        rf_wdv    = core_wr_valid ? core_wdv    : dbg_wdata;
    end

    // Starvation counter
    always_comb begin
        starve_d = '0;
        if (dbg_rd_pend && !dbg_rd_gnt) begin
            starve_d = starve_hit ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Tags of the transactions accepted this cycle
    always_comb begin
        tags_in.rd = TAG_NONE;
        if (dbg_rd_gnt) begin
            tags_in.rd = TAG_DBG_RD;
        end else if (core_rd_acc) begin
            tags_in.rd = TAG_CORE;
        end
        tags_in.wr = dbg_wr_acc ? TAG_DBG_WR : TAG_NONE;
    end

    regfile_tag_pipe u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .tags_i (tags_in),
        .tags_o (tags_out)
    );

    // Response routing; a debug read and a debug write can never share a
    // stage because debug issues one request per cycle.
    always_comb begin
        core_rdata_valid = (tags_out.rd == TAG_CORE);
        core_rs1v        = rf_rs1v;
        core_rs2v        = rf_rs2v;
        dbg_rsp_valid    = (tags_out.rd == TAG_DBG_RD) | (tags_out.wr == TAG_DBG_WR);
        dbg_rsp_data     = (tags_out.rd == TAG_DBG_RD) ? rf_rs1v : '0;
    end

endmodule
